// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester arbiter around one sequential 32x32 shift-add multiplier
// Optional MULT_ARB_RR_EN: round-robin tie breaking; undefined gives fixed priority to requester 0.
module mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 80,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    output logic               gnt0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_prod,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_load,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
`ifdef MULT_ARB_RR_EN
    logic               last_gnt_q, last_gnt_d;
`endif

    logic any_req;
    logic win_id;
    logic grant_en;

    // Grant is combinational in IDLE so the requester sees it in the same cycle its req is sampled.
    always_comb begin
        any_req = req0 | req1;
`ifdef MULT_ARB_RR_EN
        win_id  = (req0 && req1) ? ~last_gnt_q : ~req0;
`else
        win_id  = ~req0;
`endif
        grant_en = (state_q == IDLE) && any_req && !reset;
    end

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_prod_d = rsp_prod_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;
        wdog_d     = wdog_q;
`ifdef MULT_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    mul_a_d  = win_id ? a1 : a0;
                    mul_b_d  = win_id ? b1 : b0;
                    rsp_id_d = win_id;
`ifdef MULT_ARB_RR_EN
                    last_gnt_d = win_id;
`endif
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                wdog_d = wdog_q + CNT_W'(1);
                // Completion wins over the watchdog when both land in the same cycle.
                if (mul_done) begin
                    rsp_prod_d = mul_prod;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_prod_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_prod_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            wdog_q     <= '0;
`ifdef MULT_ARB_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_prod_q <= rsp_prod_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
            wdog_q     <= wdog_d;
`ifdef MULT_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign gnt0      = grant_en & ~win_id;
    assign gnt1      = grant_en & win_id;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_load  = (state_q == LOAD);
    assign mul_start = (state_q == RUN);
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter with a behavioural multiplier model
module tb_mult_arbiter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 80;
    localparam int CNT_W   = 7;
`ifdef MULT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, gnt0, gnt1;
    logic [WIDTH-1:0] a0, b0, a1, b1, mul_a, mul_b;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic mul_load, mul_start, mul_done, busy;
    logic [2*WIDTH-1:0] rsp_prod, mul_prod;

    always #5 clk = ~clk;

    mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load), .mul_start(mul_start),
        .mul_done(mul_done), .mul_prod(mul_prod), .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: one operation in service at a time.
    exp_t exp_q[$];
    int   gnt_log[$];
    bit   occupied = 1'b0;
    bit   ref_last = 1'b1;
    int   cur_g = 0, cur_due = 0;
    int   forced_delay = -1;
    int   mdl_delay = 0;
    int   n_rsp = 0;
    int   last_gnt_cyc = 0, last_acc_cyc = 0, first_valid_cyc = 0;
    logic [63:0] last_prod = '0;
    logic last_err = 1'b0, last_id = 1'b0;
    bit   prev_valid = 1'b0;
    bit   occ_before, exp_gnt, exp_w;
    logic [1:0] exp_vec;
    exp_t e;
    int   d;

    function automatic int pick_delay();
        int r = $urandom_range(0, 19);
        if (r == 0) return TIMEOUT - 1;
        if (r == 1) return TIMEOUT;
        if (r == 2) return 1000;
        return $urandom_range(0, 40);
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Multiplier model: done after mdl_delay RUN cycles (0 = first RUN cycle); garbage product otherwise.
    initial begin
        logic [63:0] mprod;
        int run_idx;
        mul_done = 1'b0;
        mul_prod = '0;
        mprod    = '0;
        run_idx  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mul_load) mprod = {32'b0, mul_a} * {32'b0, mul_b};
            if (mul_start) begin
                mul_done = (run_idx == mdl_delay);
                run_idx++;
            end else begin
                mul_done = 1'b0;
                run_idx  = 0;
            end
            mul_prod = mul_done ? mprod : {$urandom, $urandom};
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                occupied   = 1'b0;
                ref_last   = 1'b1;
                prev_valid = 1'b0;
            end else begin
                occ_before = occupied;
                chk("load_start_excl", 64'(mul_load & mul_start), 64'(0));
                chk("busy", 64'(busy), 64'(occ_before));
                if (occ_before || mul_load)
                    chk("mul_load", 64'(mul_load), 64'(occ_before && cyc == cur_g + 1));
                if (occ_before || mul_start)
                    chk("mul_start", 64'(mul_start), 64'(occ_before && cyc >= cur_g + 2 && cyc < cur_due));
                if (occ_before || rsp_valid)
                    chk("rsp_valid", 64'(rsp_valid), 64'(occ_before && cyc >= cur_due));
                if (rsp_valid && exp_q.size() > 0) begin
                    if (!prev_valid) first_valid_cyc = cyc;
                    e = exp_q[0];
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_prod", rsp_prod, e.prod);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        occupied     = 1'b0;
                        n_rsp++;
                        last_acc_cyc = cyc;
                        last_prod    = rsp_prod;
                        last_err     = rsp_err;
                        last_id      = rsp_id;
                    end
                end
                prev_valid = rsp_valid && !rsp_ready;

                exp_gnt = !occ_before && (req0 || req1);
                if (req0 && req1) exp_w = RR ? !ref_last : 1'b0;
                else              exp_w = req1;
                exp_vec = exp_gnt ? (exp_w ? 2'b10 : 2'b01) : 2'b00;
                if (exp_vec != 2'b00 || gnt0 || gnt1)
                    chk("gnt", 64'({gnt1, gnt0}), 64'(exp_vec));
                if (gnt0 || gnt1) begin
                    gnt_log.push_back(gnt1 ? 1 : 0);
                    last_gnt_cyc = cyc;
                end
                if (exp_gnt) begin
                    d = (forced_delay >= 0) ? forced_delay : pick_delay();
                    mdl_delay = d;
                    e.id   = exp_w;
                    e.err  = (d > TIMEOUT - 1);
                    e.prod = e.err ? 64'h0 :
                             (exp_w ? {32'b0, a1} * {32'b0, b1} : {32'b0, a0} * {32'b0, b0});
                    exp_q.push_back(e);
                    occupied = 1'b1;
                    cur_g    = cyc;
                    cur_due  = cyc + 3 + (e.err ? TIMEOUT - 1 : d);
                    ref_last = exp_w;
                end
            end
        end
    end

    task automatic set_req(input int id, input logic r, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin req0 = r; a0 = a; b0 = b; end
        else         begin req1 = r; a1 = a; b1 = b; end
    endtask

    task automatic wait_gnt(input int id);
        int w = 0;
        do begin @(negedge clk); w++; end while (!(id == 0 ? gnt0 : gnt1) && w < 400);
        if (!(id == 0 ? gnt0 : gnt1)) chk("gnt_wait", 64'(id == 0 ? gnt0 : gnt1), 64'(1));
    endtask

    task automatic wait_idle();
        int w = 0;
        do begin @(negedge clk); w++; end while ((busy || occupied) && w < 500);
        if (busy || occupied) chk("idle_wait", 64'({busy, occupied}), 64'(0));
    endtask

    task automatic one_op(input int id, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        set_req(id, 1'b1, a, b);
        wait_gnt(id);
        @(posedge clk); #2;
        set_req(id, 1'b0, $urandom, $urandom);
        wait_idle();
    endtask

    task automatic rand_driver(input int id, input int nops);
        bit got, gave_up, keep;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 8)) @(posedge clk);
            @(posedge clk); #2;
            set_req(id, 1'b1, rnd_op(), rnd_op());
            got = 0;
            gave_up = 0;
            for (int w = 0; w < 6000; w++) begin
                @(negedge clk);
                if ((id == 0) ? gnt0 : gnt1) begin got = 1; break; end
                if ($urandom_range(0, 49) == 0) begin gave_up = 1; break; end
            end
            if (!got && !gave_up) chk("rand_gnt_wait", 64'(got), 64'(1));
            keep = got && ($urandom_range(0, 2) == 0);
            @(posedge clk); #2;
            set_req(id, keep, $urandom, $urandom);
        end
        @(posedge clk); #2;
        set_req(id, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int n, rsp_before;
        bit rand_done;
        reset = 1'b1; rsp_ready = 1'b1;
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        set_req(0, 1'b1, 5, 3);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_gnt0", 64'(gnt0), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_mul_load", 64'(mul_load), 64'(0));
        chk("reset_mul_start", 64'(mul_start), 64'(0));
        chk("reset_mul_a", 64'(mul_a), 64'(0));
        chk("reset_rsp_prod", rsp_prod, 64'(0));
        set_req(0, 1'b0, 0, 0);
        @(posedge clk); #2 reset = 1'b0;

        // Tie: both held high across three operations.
        gnt_log.delete();
        forced_delay = 4;
        @(posedge clk); #2;
        set_req(0, 1'b1, $urandom, $urandom);
        set_req(1, 1'b1, $urandom, $urandom);
        n = 0;
        for (int w = 0; w < 600 && n < 3; w++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                n++;
                if (n < 3) begin
                    @(posedge clk); #2;
                    set_req(0, 1'b1, $urandom, $urandom);
                    set_req(1, 1'b1, $urandom, $urandom);
                end
            end
        end
        @(posedge clk); #2;
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        wait_idle();
        chk("tie_count", 64'(gnt_log.size()), 64'(3));
        chk("tie_order_0", 64'(gnt_log[0]), 64'(0));
        chk("tie_order_1", 64'(gnt_log[1]), 64'(RR));
        chk("tie_order_2", 64'(gnt_log[2]), 64'(0));

        // Single request, done on the 33rd RUN cycle.
        forced_delay = 32;
        one_op(0, 7, 6);
        chk("single_prod", last_prod, 64'd42);
        chk("single_id", 64'(last_id), 64'(0));
        chk("single_err", 64'(last_err), 64'(0));
        chk("single_latency", 64'(first_valid_cyc - last_gnt_cyc), 64'(35));

        // Backpressure with requester 1 pending.
        forced_delay = 8;
        @(posedge clk); #2;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_gnt(0);
        @(posedge clk); #2;
        set_req(0, 1'b0, $urandom, $urandom);
        set_req(1, 1'b1, $urandom, $urandom);
        rsp_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
        chk("bp_valid_seen", 64'(rsp_valid), 64'(1));
        repeat (10) @(posedge clk);
        #2 rsp_ready = 1'b1;
        wait_gnt(1);
        chk("bp_prod", last_prod, 64'h1_FFFF_FFFE);
        chk("bp_stall_cycles", 64'(last_acc_cyc - first_valid_cyc), 64'(10));
        chk("bp_gnt1_after_accept", 64'(last_gnt_cyc - last_acc_cyc), 64'(1));
        @(posedge clk); #2;
        set_req(1, 1'b0, 0, 0);
        wait_idle();

        // Watchdog abort.
        forced_delay = 1000;
        one_op(0, $urandom, $urandom);
        chk("to_err", 64'(last_err), 64'(1));
        chk("to_prod", last_prod, 64'(0));
        chk("to_latency", 64'(first_valid_cyc - last_gnt_cyc), 64'(TIMEOUT + 2));

        // Done in the same cycle as the watchdog limit.
        forced_delay = TIMEOUT - 1;
        one_op(1, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("edge_err", 64'(last_err), 64'(0));
        chk("edge_prod", last_prod, 64'h1234_5678 * 64'h9ABC_DEF0);
        chk("edge_latency", 64'(first_valid_cyc - last_gnt_cyc), 64'(TIMEOUT + 2));

        // Asynchronous reset in the middle of RUN.
        forced_delay = 50;
        @(posedge clk); #2;
        set_req(0, 1'b1, $urandom, $urandom);
        wait_gnt(0);
        @(posedge clk); #2;
        set_req(0, 1'b0, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_run", 64'(mul_start), 64'(1));
        rsp_before = n_rsp;
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_busy", 64'(busy), 64'(0));
        chk("mid_reset_mul_start", 64'(mul_start), 64'(0));
        chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (60) @(posedge clk);
        chk("mid_reset_no_rsp", 64'(n_rsp), 64'(rsp_before));
        forced_delay = 3;
        one_op(1, $urandom, $urandom);
        chk("post_reset_rsp", 64'(n_rsp), 64'(rsp_before + 1));
        chk("post_reset_id", 64'(last_id), 64'(1));

        // Randomised traffic with random backpressure and multiplier latency.
        forced_delay = -1;
        rand_done = 1'b0;
        fork
            begin
                fork
                    rand_driver(0, 25);
                    rand_driver(1, 25);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2 rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one sequential shift-add multiplier (32x32 -> 64) between two requesters.
- Arbitrates the requests, loads the operands, holds the multiplier running until it reports done, then returns the product on a single shared response channel.
- A watchdog aborts any operation that never completes.
- Sits between the ALU-side requesters (integer pipe, address-gen unit) and the multiplier instance.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- TIMEOUT, 80, max cycles in RUN before abort; must be > WIDTH+2.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0  in  1  requester 0 request; level, held until gnt0.
- a0  in  WIDTH  requester 0 multiplicand.
- b0  in  WIDTH  requester 0 multiplier.
- gnt0  out  1  one-cycle pulse; operands of requester 0 accepted.
- req1, a1, b1, gnt1  —  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester index for the response.
- rsp_prod  out  2*WIDTH  product.
- rsp_err  out  1  response is a timeout abort; rsp_prod = 0.
- mul_a  out  WIDTH  operand to multiplier multiplicand register.
- mul_b  out  WIDTH  operand to multiplier product-register low half.
- mul_load  out  1  multiplier load/reset strobe; loads mul_a/mul_b.
- mul_start  out  1  multiplier doMult; held high during RUN.
- mul_done  in  1  multiplier completion flag.
- mul_prod  in  2*WIDTH  multiplier product register.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, last_gnt=1 (so requester 0 wins first), watchdog=0, operand regs=0.
- IDLE:
  - If any req is high: pick the winner, pulse gnt of the winner for one cycle, capture its a/b into mul_a/mul_b, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): mul_load=1, mul_start=0, mul_a/mul_b stable; next state RUN, watchdog cleared.
- RUN:
  - mul_start=1; watchdog increments each cycle.
  - mul_done=1: capture mul_prod into rsp_prod, rsp_err=0, go to RESP.
  - Else if watchdog==TIMEOUT-1: rsp_prod=0, rsp_err=1, go to RESP.
  - mul_done takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1; mul_start=0; rsp_id/rsp_prod/rsp_err held stable until rsp_valid && rsp_ready, then go to IDLE.
  - No new grant is issued in the acceptance cycle; next grant is earliest the following cycle.
- Latency: grant at cycle 0 -> LOAD at cycle 1 -> RUN from cycle 2 -> rsp_valid the cycle after mul_done is sampled.
- Backpressure: rsp_ready low holds RESP indefinitely; requests remain pending (no grant).
- Requesters may change a/b after their gnt pulse; captured copies are used.
- A req dropped before gnt is simply not served.
- mul_load and mul_start are never high in the same cycle.
- busy = (state != IDLE).
- Reset mid-operation: immediate return to IDLE, outputs 0; in-flight result is discarded and no response is issued.

Optional Feature:
- Macro MULT_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high, grant goes to the requester not equal to last_gnt; last_gnt updates on every grant.
- Undefined: fixed priority, req0 always wins ties; last_gnt is unused, and requester 1 can starve under continuous req0.

Test Plan:
- Single request: req0=1, a0=7, b0=6, multiplier done after 33 cycles -> gnt0 pulse at cycle 0, mul_load at cycle 1, rsp_valid with rsp_id=0, rsp_prod=42, rsp_err=0.
- Tie handling: req0 and req1 held high through 3 operations.
  - RR defined -> grant order 0,1,0.
  - RR undefined -> 0,0,0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid, with req1 pending -> rsp_prod stable (0xFFFFFFFF*2 = 0x1_FFFFFFFE), no gnt1 until the cycle after acceptance.
- Timeout: mul_done tied low -> rsp_valid exactly TIMEOUT cycles after RUN entry, rsp_err=1, rsp_prod=0, mul_start drops.
- Done and timeout in the same cycle: mul_done asserted on watchdog==TIMEOUT-1 -> rsp_err=0 and the product is captured.
- Async reset asserted mid-RUN (between clock edges) -> busy, mul_start, and rsp_valid go 0 immediately; no response is produced; next request is served normally.
